tc_result_writeback: RTL and testbench

TC_RESULT_WRITEBACK -- requirements
Module: tc_result_writeback

---
 rtl/tc_result_writeback.sv | 108 ++++++++++
 tb/tb_tc_result_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tc_result_writeback.sv
// Tensor-core result writeback: latches one SHAPE_M x SHAPE_N result matrix and drains it
// to the register file one row per beat, with a zero-bubble hand-off to the next matrix.
module tc_result_writeback #(
   parameter int SHAPE_M    = 8,
   parameter int SHAPE_N    = 8,
   parameter int XLEN       = 8,
   parameter int VL         = 8,
   parameter int DEPTH_WARP = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [SHAPE_M*SHAPE_N*XLEN-1:0]   in_data_i,
   input  logic [VL*5-1:0]                   in_fflags_i,
   input  logic [7:0]                        in_reg_idxw_i,
   input  logic [DEPTH_WARP-1:0]             in_warpid_i,
   output logic                              wb_valid_o,
   input  logic                              wb_ready_i,
   output logic [SHAPE_N*XLEN-1:0]           wb_data_o,
   output logic [$clog2(SHAPE_M)-1:0]        wb_row_o,
   output logic [7:0]                        wb_reg_idxw_o,
   output logic [DEPTH_WARP-1:0]             wb_warpid_o,
   output logic                              wb_last_o,
   output logic [4:0]                        wb_fflags_o,
   output logic                              busy_o
);
   // state | meaning
   // IDLE  | no matrix held, ready for a new result
   // DRAIN | matrix held, emitting one row per beat handshake
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   localparam int RW    = $clog2(SHAPE_M);
   localparam int ROW_W = SHAPE_N * XLEN;
   localparam logic [RW-1:0] LAST_ROW = RW'(SHAPE_M - 1);

   logic [0:0]                        r_state;
   logic [RW-1:0]                     r_row;
   logic [SHAPE_M*SHAPE_N*XLEN-1:0]   r_data;
   logic [7:0]                        r_base;
   logic [DEPTH_WARP-1:0]             r_warp;
   logic [4:0]                        r_flags;

   logic                              w_drain;
   logic                              w_last;
   logic                              w_wb_fire;
   logic                              w_in_fire;
   logic [4:0]                        w_flags_or;
   logic [ROW_W-1:0]                  w_row_data;

   assign w_drain   = (r_state == S_DRAIN);
   assign w_last    = w_drain && (r_row == LAST_ROW);
   assign w_wb_fire = w_drain && wb_ready_i;
   // Ready never looks at in_valid_i, so upstream may wait on ready without a loop.
   assign in_ready_o = !w_drain || (wb_ready_i && w_last);
   assign w_in_fire  = in_valid_i && in_ready_o;

   always_comb begin
      w_flags_or = '0;
      for (int l = 0; l < VL; l++) begin
         w_flags_or = w_flags_or | in_fflags_i[l*5 +: 5];
      end
   end

   always_comb begin
      w_row_data = '0;
      for (int r = 0; r < SHAPE_M; r++) begin
         if (r_row == RW'(r)) begin
            w_row_data = r_data[r*ROW_W +: ROW_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_data  <= '0;
         r_base  <= '0;
         r_warp  <= '0;
         r_flags <= '0;
      end else if (w_in_fire) begin
         r_state <= S_DRAIN;
         r_row   <= '0;
         r_data  <= in_data_i;
         r_base  <= in_reg_idxw_i;
         r_warp  <= in_warpid_i;
         r_flags <= w_flags_or;
      end else if (w_wb_fire) begin
         if (w_last) begin
            r_state <= S_IDLE;
         end else begin
            r_row <= r_row + 1'b1;
         end
      end
   end

   assign busy_o        = w_drain;
   assign wb_valid_o    = w_drain;
   assign wb_data_o     = w_drain ? w_row_data : '0;
   assign wb_row_o      = w_drain ? r_row : '0;
   assign wb_reg_idxw_o = w_drain ? (r_base + 8'(r_row)) : 8'h00;
   assign wb_warpid_o   = w_drain ? r_warp : '0;
   assign wb_last_o     = w_last;
   assign wb_fflags_o   = w_last ? r_flags : 5'b00000;

endmodule

// File: tb/tb_tc_result_writeback.sv
// Bench for tc_result_writeback: queue-of-beats reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_tc_result_writeback;
   localparam int M = 8, N = 8, X = 8, V = 8, W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [M*N*X-1:0]  in_data_i;
   logic [V*5-1:0]    in_fflags_i;
   logic [7:0]        in_reg_idxw_i;
   logic [W-1:0]      in_warpid_i;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic [N*X-1:0]    wb_data_o;
   logic [2:0]        wb_row_o;
   logic [7:0]        wb_reg_idxw_o;
   logic [W-1:0]      wb_warpid_o;
   logic              wb_last_o;
   logic [4:0]        wb_fflags_o;
   logic              busy_o;

   tc_result_writeback #(.SHAPE_M(M), .SHAPE_N(N), .XLEN(X), .VL(V), .DEPTH_WARP(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .in_fflags_i(in_fflags_i), .in_reg_idxw_i(in_reg_idxw_i), .in_warpid_i(in_warpid_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
      .wb_row_o(wb_row_o), .wb_reg_idxw_o(wb_reg_idxw_o), .wb_warpid_o(wb_warpid_o),
      .wb_last_o(wb_last_o), .wb_fflags_o(wb_fflags_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the beats still owed to the register file, in order.
   typedef struct {
      logic [63:0] data;
      logic [2:0]  row;
      logic [7:0]  idx;
      logic [W-1:0] warp;
      logic        last;
      logic [4:0]  flags;
   } beat_t;

   beat_t q[$];
   bit    started = 0;

   always @(posedge clk) begin
      bit    exp_rdy;
      beat_t b;
      logic [4:0] f;
      if (rst) begin
         q.delete();
         started = 1;
      end else if (started) begin
         exp_rdy = (q.size() == 0) || (q.size() == 1 && wb_ready_i);
         if (q.size() > 0 && wb_ready_i) void'(q.pop_front());
         if (in_valid_i && exp_rdy) begin
            f = 5'b0;
            for (int l = 0; l < V; l++) f = f | in_fflags_i[l*5 +: 5];
            for (int r = 0; r < M; r++) begin
               b.data  = in_data_i[r*64 +: 64];
               b.row   = 3'(r);
               b.idx   = 8'((int'(in_reg_idxw_i) + r) % 256);
               b.warp  = in_warpid_i;
               b.last  = (r == M - 1);
               b.flags = (r == M - 1) ? f : 5'b0;
               q.push_back(b);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         if (q.size() == 0) begin
            chk("idle_valid", wb_valid_o, 0);
            chk("idle_busy", busy_o, 0);
            chk("idle_ready", in_ready_o, 1);
            chk("idle_data", wb_data_o, 0);
            chk("idle_side", {wb_row_o, wb_reg_idxw_o, wb_warpid_o, wb_last_o, wb_fflags_o}, 0);
         end else begin
            chk("valid", wb_valid_o, 1);
            chk("busy", busy_o, 1);
            chk("ready", in_ready_o, (q.size() == 1 && wb_ready_i));
            chk("data", wb_data_o, q[0].data);
            chk("row", wb_row_o, q[0].row);
            chk("idx", wb_reg_idxw_o, q[0].idx);
            chk("warp", wb_warpid_o, q[0].warp);
            chk("last", wb_last_o, q[0].last);
            chk("fflags", wb_fflags_o, q[0].flags);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pattern(input logic [7:0] off);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            in_data_i[(i*N + j)*X +: X] = 8'(i*N + j) + off;
   endtask

   initial begin
      int cnt;
      rst = 1; in_valid_i = 0; wb_ready_i = 1; in_data_i = '0;
      in_fflags_i = '0; in_reg_idxw_i = 8'h00; in_warpid_i = '0;
      step(); step();
      rst = 0;
      chk("rst_valid", wb_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", in_ready_o, 1);
      chk("rst_data", wb_data_o, 0);

      // Basic drain with flags on lanes 3 and 6
      set_pattern(8'h00);
      in_reg_idxw_i = 8'h10; in_warpid_i = 3'd5;
      in_fflags_i = '0;
      in_fflags_i[3*5 +: 5] = 5'b00100;
      in_fflags_i[6*5 +: 5] = 5'b00001;
      in_valid_i = 1;
      step();
      in_valid_i = 0;
      in_fflags_i = '0;
      for (int r = 0; r < M; r++) begin
         chk("a_valid", wb_valid_o, 1);
         chk("a_idx", wb_reg_idxw_o, 64'(8'h10 + r));
         chk("a_last", wb_last_o, (r == 7));
         chk("a_flags", wb_fflags_o, (r == 7) ? 5'b00101 : 5'b00000);
         chk("a_warp", wb_warpid_o, 5);
         if (r == 0) chk("a_row0", wb_data_o, 64'h0706050403020100);
         if (r == 7) chk("a_row7", wb_data_o, 64'h3f3e3d3c3b3a3938);
         step();
      end
      chk("a_done", wb_valid_o, 0);

      // Register index wrap
      in_reg_idxw_i = 8'hFC; in_valid_i = 1;
      step();
      in_valid_i = 0;
      for (int r = 0; r < M; r++) begin
         if (r >= 4) chk("b_wrap_idx", wb_reg_idxw_o, 64'(r - 4));
         step();
      end

      // Back-pressure on row 2
      in_reg_idxw_i = 8'h00; in_valid_i = 1;
      step();
      in_valid_i = 0;
      step(); step();
      wb_ready_i = 0;
      for (int k = 0; k < 3; k++) begin
         chk("c_hold_row", wb_row_o, 2);
         chk("c_hold_ready", in_ready_o, 0);
         chk("c_hold_data", wb_data_o, 64'h1716151413121110);
         step();
      end
      wb_ready_i = 1;
      chk("c_row2_again", wb_row_o, 2);
      step();
      chk("c_row3", wb_row_o, 3);
      for (int k = 0; k < 5; k++) step();
      chk("c_done", wb_valid_o, 0);

      // Two matrices back to back, second held during drain
      set_pattern(8'h00);
      in_reg_idxw_i = 8'h20; in_warpid_i = 3'd1; in_valid_i = 1;
      step();
      set_pattern(8'h80);
      in_reg_idxw_i = 8'h40; in_warpid_i = 3'd2;
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (wb_valid_o && wb_ready_i) cnt++;
         if (c == 6) chk("d_not_ready_row6", in_ready_o, 0);
         if (c == 7) chk("d_ready_row7", in_ready_o, 1);
         if (c == 8) begin
            chk("d_new_row0", wb_row_o, 0);
            chk("d_new_idx", wb_reg_idxw_o, 8'h40);
            chk("d_new_data", wb_data_o, 64'h8786858483828180);
            in_valid_i = 0;
         end
         step();
      end
      chk("d_beats", cnt, 16);
      chk("d_done", wb_valid_o, 0);

      // Reset during row 4
      set_pattern(8'h00);
      in_reg_idxw_i = 8'h30; in_valid_i = 1;
      step();
      in_valid_i = 0;
      for (int k = 0; k < 4; k++) step();
      chk("e_row4", wb_row_o, 4);
      rst = 1;
      step();
      rst = 0;
      chk("e_valid", wb_valid_o, 0);
      chk("e_busy", busy_o, 0);
      chk("e_ready", in_ready_o, 1);
      in_reg_idxw_i = 8'h50; in_valid_i = 1;
      step();
      in_valid_i = 0;
      chk("e_restart_row", wb_row_o, 0);
      chk("e_restart_idx", wb_reg_idxw_o, 8'h50);
      for (int k = 0; k < 8; k++) step();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         in_valid_i = ($urandom % 3) != 0;
         wb_ready_i = ($urandom % 4) != 0;
         rst = ($urandom % 97) == 0;
         for (int w = 0; w < M*N*X/32; w++) in_data_i[w*32 +: 32] = $urandom;
         in_fflags_i = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         in_reg_idxw_i = 8'($urandom);
         in_warpid_i = W'($urandom);
         step();
      end
      rst = 0; in_valid_i = 0; wb_ready_i = 1;
      for (int k = 0; k < 10; k++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
